// File: rtl/id_stage_pipe.sv
// Decode stage: register file read, immediates, load-use stall,
// and the ID/EX pipeline register.
module id_stage_pipe #(
   parameter int DW = 64,
   parameter int AW = 5,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic [31:0]   id_instruction,
   input  logic          reg2loc,
   input  logic          uncond_br,
   input  logic          mem_read,
   input  logic [CW-1:0] ctrl_in,
   input  logic          flush,
   input  logic          wb_regwrite,
   input  logic [AW-1:0] wb_rd,
   input  logic [DW-1:0] wb_data,
   output logic          stall,
   output logic          ex_valid,
   output logic          ex_mem_read,
   output logic [CW-1:0] ex_ctrl,
   output logic [AW-1:0] ex_rn,
   output logic [AW-1:0] ex_rm,
   output logic [AW-1:0] ex_rd,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [DW-1:0] ex_imm12,
   output logic [DW-1:0] ex_daddr9,
   output logic [DW-1:0] ex_br_offset
);

   localparam int NR = 2**AW;
   localparam logic [AW-1:0] ZR = {AW{1'b1}};

   // 5-bit instruction field to AW-bit index (truncate or zero-extend)
   function automatic logic [AW-1:0] idx(input logic [4:0] f);
      logic [31:0] t;
      t = {27'd0, f};
      return t[AW-1:0];
   endfunction

   logic [AW-1:0] rn, rm, rd, ab;
   logic [DW-1:0] rd_a, rd_b;
   logic [DW-1:0] imm12, daddr9, br_off;
   logic          stall_c;
   logic          unused_hi;

   logic [DW-1:0] rf_q [NR];
   logic [DW-1:0] rf_d [NR];

   logic          ex_valid_q, ex_valid_d;
   logic          ex_mem_read_q, ex_mem_read_d;
   logic [CW-1:0] ex_ctrl_q, ex_ctrl_d;
   logic [AW-1:0] ex_rn_q, ex_rn_d;
   logic [AW-1:0] ex_rm_q, ex_rm_d;
   logic [AW-1:0] ex_rd_q, ex_rd_d;
   logic [DW-1:0] ex_a_q, ex_a_d;
   logic [DW-1:0] ex_b_q, ex_b_d;
   logic [DW-1:0] ex_imm12_q, ex_imm12_d;
   logic [DW-1:0] ex_daddr9_q, ex_daddr9_d;
   logic [DW-1:0] ex_br_offset_q, ex_br_offset_d;

   assign unused_hi = ^id_instruction[31:26];

   // Field extraction and immediate generation
   always_comb begin
      rn     = idx(id_instruction[9:5]);
      rm     = idx(id_instruction[20:16]);
      rd     = idx(id_instruction[4:0]);
      ab     = reg2loc ? rm : rd;
      imm12  = DW'(id_instruction[21:10]);
      daddr9 = DW'($signed(id_instruction[20:12]));
      if (uncond_br)
         br_off = DW'($signed(id_instruction[25:0]));
      else
         br_off = DW'($signed(id_instruction[23:5]));
   end

   // Register reads with write-through bypass; zero register reads 0
   always_comb begin
      rd_a = rf_q[rn];
      rd_b = rf_q[ab];
      if (wb_regwrite && wb_rd == rn)
         rd_a = wb_data;
      if (wb_regwrite && wb_rd == ab)
         rd_b = wb_data;
      if (rn == ZR)
         rd_a = '0;
      if (ab == ZR)
         rd_b = '0;
   end

   // Load-use hazard: the load in EX targets a source of the decode instr
   always_comb begin
      stall_c = !reset && id_valid && ex_valid_q && ex_mem_read_q
                && (ex_rd_q != ZR) && (ex_rd_q == rn || ex_rd_q == ab)
                && !flush;
   end

   assign stall = stall_c;

   // Register file next state; the zero register is never written
   always_comb begin
      rf_d = rf_q;
      if (wb_regwrite && wb_rd != ZR)
         rf_d[wb_rd] = wb_data;
   end

   // Register file storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NR; i++)
            rf_q[i] <= '0;
      end else begin
         rf_q <= rf_d;
      end
   end

   // ID/EX next state: decoded fields, or a bubble on flush/stall
   always_comb begin
      ex_valid_d     = id_valid;
      ex_mem_read_d  = mem_read & id_valid;
      ex_ctrl_d      = id_valid ? ctrl_in : '0;
      ex_rn_d        = rn;
      ex_rm_d        = rm;
      ex_rd_d        = rd;
      ex_a_d         = rd_a;
      ex_b_d         = rd_b;
      ex_imm12_d     = imm12;
      ex_daddr9_d    = daddr9;
      ex_br_offset_d = br_off;
      if (flush || stall_c) begin
         ex_valid_d    = 1'b0;
         ex_mem_read_d = 1'b0;
         ex_ctrl_d     = '0;
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_q     <= 1'b0;
         ex_mem_read_q  <= 1'b0;
         ex_ctrl_q      <= '0;
         ex_rn_q        <= '0;
         ex_rm_q        <= '0;
         ex_rd_q        <= '0;
         ex_a_q         <= '0;
         ex_b_q         <= '0;
         ex_imm12_q     <= '0;
         ex_daddr9_q    <= '0;
         ex_br_offset_q <= '0;
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_mem_read_q  <= ex_mem_read_d;
         ex_ctrl_q      <= ex_ctrl_d;
         ex_rn_q        <= ex_rn_d;
         ex_rm_q        <= ex_rm_d;
         ex_rd_q        <= ex_rd_d;
         ex_a_q         <= ex_a_d;
         ex_b_q         <= ex_b_d;
         ex_imm12_q     <= ex_imm12_d;
         ex_daddr9_q    <= ex_daddr9_d;
         ex_br_offset_q <= ex_br_offset_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign ex_mem_read  = ex_mem_read_q;
   assign ex_ctrl      = ex_ctrl_q;
   assign ex_rn        = ex_rn_q;
   assign ex_rm        = ex_rm_q;
   assign ex_rd        = ex_rd_q;
   assign ex_a         = ex_a_q;
   assign ex_b         = ex_b_q;
   assign ex_imm12     = ex_imm12_q;
   assign ex_daddr9    = ex_daddr9_q;
   assign ex_br_offset = ex_br_offset_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: stimulus pushes expected ID/EX
// contents, a monitor pops and compares after every rising edge.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_instruction;
   logic        reg2loc, uncond_br, mem_read;
   logic [7:0]  ctrl_in;
   logic        flush;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        stall;
   logic        ex_valid, ex_mem_read;
   logic [7:0]  ex_ctrl;
   logic [4:0]  ex_rn, ex_rm, ex_rd;
   logic [63:0] ex_a, ex_b, ex_imm12, ex_daddr9, ex_br_offset;

   id_stage_pipe dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_instruction(id_instruction), .reg2loc(reg2loc),
      .uncond_br(uncond_br), .mem_read(mem_read), .ctrl_in(ctrl_in),
      .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid),
      .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl), .ex_rn(ex_rn),
      .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
      .ex_imm12(ex_imm12), .ex_daddr9(ex_daddr9),
      .ex_br_offset(ex_br_offset)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      bit          r2l, ub, mr, v, fl, we;
      logic [7:0]  ctrl;
      logic [4:0]  wrd;
      logic [63:0] wd;
   } stim_t;

   typedef struct {
      bit          v, mr;
      logic [7:0]  ctrl;
      logic [4:0]  rn, rm, rd;
      logic [63:0] a, b, imm, da, br;
   } exp_t;

   exp_t        q[$];
   logic [63:0] regs [32];
   bit          m_v, m_mr;
   logic [4:0]  m_rd;
   bit          last_st;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", n, act, exp);
      end
   endtask

   // n-bit two's complement field as a 64-bit integer value
   function automatic logic [63:0] sx(logic [31:0] v, int n);
      logic [63:0] r;
      r = 64'(v);
      if (v[n-1]) r = r - (64'd1 << n);
      return r;
   endfunction

   function automatic logic [63:0] mread(logic [4:0] r, stim_t s);
      if (r == 5'd31) return 64'd0;
      if (s.we && s.wrd == r) return s.wd;
      return regs[r];
   endfunction

   function automatic stim_t mk(logic [31:0] ins);
      stim_t s;
      s.ins = ins; s.r2l = 1'b1; s.ub = 1'b0; s.mr = 1'b0;
      s.v = 1'b1; s.fl = 1'b0; s.we = 1'b0; s.ctrl = 8'h5A;
      s.wrd = 5'd0; s.wd = 64'd0;
      return s;
   endfunction

   function automatic logic [31:0] rr(logic [4:0] rn, logic [4:0] rm,
                                      logic [4:0] rd);
      return {11'b10001011000, rm, 6'd0, rn, rd};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) regs[i] = 64'd0;
      m_v = 1'b0; m_mr = 1'b0; m_rd = 5'd0; last_st = 1'b0;
   endfunction

   task automatic apply(stim_t s);
      id_instruction = s.ins; reg2loc = s.r2l; uncond_br = s.ub;
      mem_read = s.mr; id_valid = s.v; flush = s.fl; ctrl_in = s.ctrl;
      wb_regwrite = s.we; wb_rd = s.wrd; wb_data = s.wd;
   endtask

   // One decode cycle: drive, check stall, push expected ID/EX content
   task automatic drive(stim_t s);
      logic [4:0] rn, rm, rd, ab;
      bit st;
      exp_t e;
      @(negedge clk);
      apply(s);
      #1;
      rn = s.ins[9:5]; rm = s.ins[20:16]; rd = s.ins[4:0];
      ab = s.r2l ? rm : rd;
      st = s.v && m_v && m_mr && m_rd != 5'd31
           && (m_rd == rn || m_rd == ab) && !s.fl;
      chk("stall", {63'd0, stall}, {63'd0, st});
      e.v = s.v && !s.fl && !st;
      e.mr = e.v && s.mr;
      e.ctrl = e.v ? s.ctrl : 8'd0;
      e.rn = rn; e.rm = rm; e.rd = rd;
      e.a = mread(rn, s);
      e.b = mread(ab, s);
      e.imm = 64'(s.ins[21:10]);
      e.da = sx({23'd0, s.ins[20:12]}, 9);
      e.br = s.ub ? sx({6'd0, s.ins[25:0]}, 26)
                  : sx({13'd0, s.ins[23:5]}, 19);
      q.push_back(e);
      if (s.we && s.wrd != 5'd31) regs[s.wrd] = s.wd;
      m_v = e.v; m_mr = e.mr; m_rd = rd;
      last_st = st;
   endtask

   // Monitor: compare ID/EX after each edge that has a pending entry
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.v});
         chk("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, e.mr});
         chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, e.ctrl});
         if (e.v) begin
            chk("ex_rn", {59'd0, ex_rn}, {59'd0, e.rn});
            chk("ex_rm", {59'd0, ex_rm}, {59'd0, e.rm});
            chk("ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
            chk("ex_a", ex_a, e.a);
            chk("ex_b", ex_b, e.b);
            chk("ex_imm12", ex_imm12, e.imm);
            chk("ex_daddr9", ex_daddr9, e.da);
            chk("ex_br_offset", ex_br_offset, e.br);
         end
      end
   end

   task automatic chk_zero(string n);
      chk({n, "_valid"}, {63'd0, ex_valid}, 64'd0);
      chk({n, "_mr"}, {63'd0, ex_mem_read}, 64'd0);
      chk({n, "_ctrl"}, {56'd0, ex_ctrl}, 64'd0);
      chk({n, "_rd"}, {59'd0, ex_rd}, 64'd0);
      chk({n, "_a"}, ex_a, 64'd0);
      chk({n, "_b"}, ex_b, 64'd0);
      chk({n, "_br"}, ex_br_offset, 64'd0);
      chk({n, "_stall"}, {63'd0, stall}, 64'd0);
   endtask

   function automatic logic [4:0] pick();
      logic [4:0] t [5];
      t[0] = 5'd1; t[1] = 5'd2; t[2] = 5'd3; t[3] = 5'd5; t[4] = 5'd31;
      if ($urandom_range(0, 3) == 0) return 5'($urandom);
      return t[$urandom_range(0, 4)];
   endfunction

   initial begin
      stim_t s, prev;
      model_reset();
      s = mk(32'd0);
      s.v = 1'b0; s.ctrl = 8'd0;
      apply(s);
      reset = 1'b1;
      #3;
      chk_zero("rst");
      @(negedge clk);
      reset = 1'b0;

      // X0..X30 read zero after reset
      for (int n = 0; n < 31; n++)
         drive(mk(rr(5'(n), 5'(n), 5'd0)));
      // write 0xDEAD to the zero register, then read it
      s = mk(rr(5'd31, 5'd31, 5'd1));
      s.we = 1'b1; s.wrd = 5'd31; s.wd = 64'hDEAD;
      drive(s);
      drive(mk(rr(5'd31, 5'd31, 5'd1)));
      @(posedge clk); #2;
      chk("zr_a", ex_a, 64'd0);

      // write-through bypass
      s = mk(rr(5'd3, 5'd0, 5'd2));
      s.we = 1'b1; s.wrd = 5'd3; s.wd = 64'h1234;
      drive(s);
      @(posedge clk); #2;
      chk("bypass_a", ex_a, 64'h1234);

      // load-use: one bubble, then issue
      s = mk(rr(5'd1, 5'd2, 5'd5)); s.mr = 1'b1;
      drive(s);
      drive(mk(rr(5'd5, 5'd2, 5'd6)));
      chk("lu_stall", {63'd0, last_st}, 64'd1);
      drive(mk(rr(5'd5, 5'd2, 5'd6)));
      chk("lu_issue", {63'd0, last_st}, 64'd0);
      // load to the zero register: no stall
      s = mk(rr(5'd1, 5'd2, 5'd31)); s.mr = 1'b1;
      drive(s);
      drive(mk(rr(5'd31, 5'd2, 5'd6)));
      // flush outranks stall
      s = mk(rr(5'd1, 5'd2, 5'd5)); s.mr = 1'b1;
      drive(s);
      s = mk(rr(5'd5, 5'd5, 5'd6)); s.fl = 1'b1;
      drive(s);

      // immediates
      s = mk(32'h17FFFFFF); s.ub = 1'b1;
      drive(s);
      @(posedge clk); #2;
      chk("br26", ex_br_offset, 64'hFFFF_FFFF_FFFF_FFFF);
      s = mk({11'd0, 9'h100, 12'd0});
      drive(s);
      @(posedge clk); #2;
      chk("daddr9", ex_daddr9, 64'hFFFF_FFFF_FFFF_FF00);
      s = mk({10'd0, 12'hFFF, 10'd0});
      drive(s);
      @(posedge clk); #2;
      chk("imm12", ex_imm12, 64'hFFF);

      // random traffic; hold decode inputs while stalled
      prev = mk(32'd0);
      for (int i = 0; i < 600; i++) begin
         if (last_st) begin
            s = prev;
         end else begin
            s.ins = $urandom;
            s.ins[9:5] = pick(); s.ins[20:16] = pick();
            s.ins[4:0] = pick();
            s.r2l = 1'($urandom); s.ub = 1'($urandom);
            s.mr = ($urandom_range(0, 2) == 0);
            s.v = ($urandom_range(0, 7) != 0);
            s.ctrl = 8'($urandom);
         end
         s.fl = ($urandom_range(0, 9) == 0);
         s.we = 1'($urandom); s.wrd = pick();
         s.wd = {$urandom, $urandom};
         prev = s;
         drive(s);
      end

      // asynchronous reset in the middle of a stall
      s = mk(rr(5'd1, 5'd2, 5'd7)); s.mr = 1'b1;
      drive(s);
      @(posedge clk); #2;
      @(negedge clk);
      apply(mk(rr(5'd7, 5'd2, 5'd8)));
      #1;
      chk("mid_stall", {63'd0, stall}, 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_zero("async_rst");
      model_reset();
      @(posedge clk); #2;
      q.delete();
      reset = 1'b0;
      drive(mk(rr(5'd7, 5'd2, 5'd8)));
      chk("post_rst", {63'd0, last_st}, 64'd0);

      repeat (2) @(posedge clk);
      #3;
      chk("q_drained", 64'(q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
